algn_rx_fifo: RTL and testbench
===============================

ALGN_RX_FIFO -- requirements
Module: algn_rx_fifo

Interface
- REQ-001: Parameter DATA_WIDTH, default 32, width of the data word in bits (8, 16 or 32).
- REQ-002: Parameter DEPTH, default 8, number of entries; power of two, 2..64.
- REQ-003: Parameter AF_LEVEL, default DEPTH-2, almost-full threshold in entries.
- REQ-004: clk  in  1  single clock; all logic on rising edge.
- REQ-005: reset  in  1  synchronous, active-high reset.
- REQ-006: push_valid  in  1  upstream RX side offers an entry.
- REQ-007: push_ready  out  1  FIFO accepts an entry this cycle.
- REQ-008: push_data  in  DATA_WIDTH  entry data.
- REQ-009: push_offset  in  2  byte offset of the entry.
- REQ-010: push_size  in  3  byte count of the entry, legal 1..4.
- REQ-011: pop_valid  out  1  head entry is available to the aligner controller.
- REQ-012: pop_ready  in  1  controller consumes the head entry.
- REQ-013: pop_data / pop_offset / pop_size  out  DATA_WIDTH / 2 / 3  head entry fields.
- REQ-014: rx_fifo_push  out  1  one-cycle pulse per accepted push.
- REQ-015: rx_fifo_pop  out  1  one-cycle pulse per accepted pop.
- REQ-016: level  out  $clog2(DEPTH)+1  current number of stored entries.
- REQ-017: drop_cnt  out  8  saturating count of rejected pushes.
- REQ-018: almost_full  out  1  level >= AF_LEVEL (present only with ALGN_RX_FIFO_AF_EN).

Function
- REQ-019: Push accepted SHALL be push_valid & push_ready; push_ready = (level != DEPTH).
- REQ-020: Pop accepted SHALL be pop_valid & pop_ready; pop_valid = (level != 0).
- REQ-021: Storage SHALL be a circular buffer with write and read pointers wrapping from DEPTH-1 to 0.
- REQ-022: Head fields SHALL be driven from the read-pointer entry (first-word fall-through); values are don't-care while pop_valid=0.
- REQ-023: Write-to-read latency SHALL be one cycle: an entry pushed in cycle N is visible with pop_valid=1 in cycle N+1; no same-cycle bypass when empty.
- REQ-024: Simultaneous accepted push and pop SHALL leave level unchanged and advance both pointers.
- REQ-025: When full, push_ready=0 even if a pop is accepted the same cycle; the push is rejected.
- REQ-026: A cycle with push_valid=1 and push_ready=0 SHALL increment drop_cnt by 1, saturating at 255; data SHALL not be written.
- REQ-027: rx_fifo_push and rx_fifo_pop SHALL be registered, asserted the cycle after the corresponding acceptance, for exactly one cycle per acceptance.
- REQ-028: Pop with pop_valid=0 SHALL have no effect on state.
- REQ-029: Entries with push_size of 0 or >4 SHALL be stored unchanged; checking is the controller's job.
- REQ-030: level SHALL be registered and equal pushes minus pops accepted since reset, never exceeding DEPTH.

Reset
- REQ-031: While reset=1 at a rising edge: pointers=0, level=0, drop_cnt=0, rx_fifo_push=0, rx_fifo_pop=0, almost_full=0.
- REQ-032: Consequently push_ready=1 and pop_valid=0 in the cycle after reset; storage contents are not cleared.
- REQ-033: Reset asserted mid-transfer SHALL discard all entries; pushes/pops presented in the reset cycle SHALL be ignored.

Configuration
- REQ-034: Macro ALGN_RX_FIFO_AF_EN defined: almost_full port exists, registered, updates one cycle after level crosses AF_LEVEL in either direction.
- REQ-035: Macro ALGN_RX_FIFO_AF_EN undefined: almost_full port and its register are absent; all other behaviour identical.

Verification
- REQ-036: Reset, then single push data=0xA5A5_0001 offset=1 size=2 -> pop_valid=1 next cycle with same fields; rx_fifo_push pulse one cycle later; level=1.
- REQ-037: 8 pushes with pop_ready=0 (DEPTH=8) -> level=8, push_ready=0; 9th push -> drop_cnt=1, 9th data never popped.
- REQ-038: Full FIFO, push_valid=1 and pop_ready=1 same cycle -> pop accepted, push rejected, level=7, drop_cnt increments.
- REQ-039: Level 3, continuous push+pop for 20 cycles -> level stays 3, pointers wrap, pop order matches push order exactly.
- REQ-040: Reset asserted with level=5 -> next cycle level=0, pop_valid=0, drop_cnt=0; 300 rejected pushes afterwards -> drop_cnt=255.
- REQ-041: With ALGN_RX_FIFO_AF_EN, AF_LEVEL=6: 6th push -> almost_full=1 one cycle after level=6; one pop -> almost_full=0 one cycle after level=5.

Source files
------------

// File: rtl/algn_rx_fifo_if.sv
// Push/pop handshake bundle between the RX side, the aligner RX FIFO and the aligner controller.
// A transfer happens on a rising clk edge where valid and ready are both 1; valid never waits on ready.
interface algn_rx_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  push_valid;
  logic                  push_ready;
  logic [DATA_WIDTH-1:0] push_data;
  logic [1:0]            push_offset;
  logic [2:0]            push_size;

  logic                  pop_valid;
  logic                  pop_ready;
  logic [DATA_WIDTH-1:0] pop_data;
  logic [1:0]            pop_offset;
  logic [2:0]            pop_size;

  modport master (
    output push_valid, push_data, push_offset, push_size, pop_ready,
    input  push_ready, pop_valid, pop_data, pop_offset, pop_size
  );

  modport slave (
    input  push_valid, push_data, push_offset, push_size, pop_ready,
    output push_ready, pop_valid, pop_data, pop_offset, pop_size
  );
endinterface

// File: rtl/algn_rx_fifo.sv
// Aligner RX FIFO: circular buffer with first-word fall-through head, drop counter and event pulses.
// Optional almost_full output is built only when ALGN_RX_FIFO_AF_EN is defined.
module algn_rx_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
`ifdef ALGN_RX_FIFO_AF_EN
  , parameter int AF_LEVEL = DEPTH - 2
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  algn_rx_fifo_if.slave          bus,
  output logic                   rx_fifo_push,
  output logic                   rx_fifo_pop,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             drop_cnt
`ifdef ALGN_RX_FIFO_AF_EN
  , output logic                 almost_full
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = DATA_WIDTH + 5;

  // Stored entry layout: {size, offset, data}
  typedef logic [EW-1:0] entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    drop_q, drop_d;
  logic          push_pulse_q, push_pulse_d;
  logic          pop_pulse_q, pop_pulse_d;
  logic          push_fire, pop_fire;

  // Readiness depends only on the registered level, so a pop cannot free a slot for a same-cycle push.
  assign bus.push_ready = (level_q != LW'(DEPTH));
  assign bus.pop_valid  = (level_q != '0);
  assign push_fire      = bus.push_valid & bus.push_ready;
  assign pop_fire       = bus.pop_valid & bus.pop_ready;

  assign head           = mem_q[rd_ptr_q];
  assign bus.pop_data   = head[DATA_WIDTH-1:0];
  assign bus.pop_offset = head[DATA_WIDTH+1:DATA_WIDTH];
  assign bus.pop_size   = head[EW-1:DATA_WIDTH+2];

  assign rx_fifo_push   = push_pulse_q;
  assign rx_fifo_pop    = pop_pulse_q;
  assign level          = level_q;
  assign drop_cnt       = drop_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    drop_d       = drop_q;
    push_pulse_d = push_fire;
    pop_pulse_d  = pop_fire;

    if (push_fire) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_fire)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push_fire, pop_fire})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (bus.push_valid && !bus.push_ready && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      drop_q       <= '0;
      push_pulse_q <= 1'b0;
      pop_pulse_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      drop_q       <= drop_d;
      push_pulse_q <= push_pulse_d;
      pop_pulse_q  <= pop_pulse_d;
    end
  end

  // Storage is never cleared; entries are stored verbatim, size legality is checked downstream.
  always_ff @(posedge clk) begin
    if (push_fire && !reset) mem_q[wr_ptr_q] <= {bus.push_size, bus.push_offset, bus.push_data};
  end

`ifdef ALGN_RX_FIFO_AF_EN
  logic almost_full_q, almost_full_d;

  assign almost_full_d = (level_q >= LW'(AF_LEVEL));
  assign almost_full   = almost_full_q;

  always_ff @(posedge clk) begin
    if (reset) almost_full_q <= 1'b0;
    else       almost_full_q <= almost_full_d;
  end
`endif
endmodule

// File: tb/tb_algn_rx_fifo.sv
// Bench for algn_rx_fifo: queue-based reference model, directed scenarios plus random traffic.
module tb_algn_rx_fifo;
  localparam int DW       = 32;
  localparam int DEPTH    = 8;
  localparam int AF_LEVEL = DEPTH - 2;
  localparam int W        = DW + 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_fifo_push;
  logic       rx_fifo_pop;
  logic [3:0] level;
  logic [7:0] drop_cnt;
`ifdef ALGN_RX_FIFO_AF_EN
  logic       almost_full;
`endif

  algn_rx_fifo_if #(.DATA_WIDTH(DW)) bus_if ();

  algn_rx_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus_if.slave),
    .rx_fifo_push (rx_fifo_push),
    .rx_fifo_pop  (rx_fifo_pop),
    .level        (level),
    .drop_cnt     (drop_cnt)
`ifdef ALGN_RX_FIFO_AF_EN
    , .almost_full (almost_full)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state: exp_q holds {size, offset, data} in push order
  logic [W-1:0] exp_q[$];
  int           exp_drop;
  logic         exp_push_p;
  logic         exp_pop_p;
  logic         exp_af;
  int           total = 0;
  int           bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [W-1:0] head;
    chk("level", 64'(level), 64'(exp_q.size()));
    chk("push_ready", 64'(bus_if.push_ready), 64'(exp_q.size() != DEPTH));
    chk("pop_valid", 64'(bus_if.pop_valid), 64'(exp_q.size() != 0));
    chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    chk("rx_fifo_push", 64'(rx_fifo_push), 64'(exp_push_p));
    chk("rx_fifo_pop", 64'(rx_fifo_pop), 64'(exp_pop_p));
`ifdef ALGN_RX_FIFO_AF_EN
    chk("almost_full", 64'(almost_full), 64'(exp_af));
`endif
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      chk("pop_data", 64'(bus_if.pop_data), 64'(head[DW-1:0]));
      chk("pop_offset", 64'(bus_if.pop_offset), 64'(head[DW+1:DW]));
      chk("pop_size", 64'(bus_if.pop_size), 64'(head[W-1:DW+2]));
    end
  endtask

  // Driver: apply one cycle of inputs, advance the model at the edge, check 1ns later
  task automatic cycle(input logic rst, input logic pv, input logic pr,
                       input logic [DW-1:0] pd, input logic [1:0] po, input logic [2:0] ps);
    int   lvl;
    logic acc_push;
    logic acc_pop;
    reset              = rst;
    bus_if.push_valid  = pv;
    bus_if.pop_ready   = pr;
    bus_if.push_data   = pd;
    bus_if.push_offset = po;
    bus_if.push_size   = ps;
    lvl      = exp_q.size();
    acc_push = pv && (lvl != DEPTH);
    acc_pop  = pr && (lvl != 0);
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_drop   = 0;
      exp_push_p = 1'b0;
      exp_pop_p  = 1'b0;
      exp_af     = 1'b0;
    end else begin
      exp_af = (lvl >= AF_LEVEL);
      if (acc_pop) void'(exp_q.pop_front());
      if (acc_push) exp_q.push_back({ps, po, pd});
      if (pv && !acc_push && exp_drop < 255) exp_drop++;
      exp_push_p = acc_push;
      exp_pop_p  = acc_pop;
    end
    #1;
    check_all();
  endtask

  task automatic rnd_cycle(input logic rst, input logic pv, input logic pr);
    cycle(rst, pv, pr, $urandom(), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
  endtask

  initial begin
    reset              = 1'b1;
    bus_if.push_valid  = 1'b0;
    bus_if.pop_ready   = 1'b0;
    bus_if.push_data   = '0;
    bus_if.push_offset = '0;
    bus_if.push_size   = '0;
    exp_drop   = 0;
    exp_push_p = 1'b0;
    exp_pop_p  = 1'b0;
    exp_af     = 1'b0;

    // Reset, with traffic offered during reset that must be ignored
    rnd_cycle(1'b1, 1'b0, 1'b0);
    rnd_cycle(1'b1, 1'b1, 1'b1);

    // Single push, fall-through head next cycle, then pulse clears
    cycle(1'b0, 1'b1, 1'b0, 32'hA5A5_0001, 2'd1, 3'd2);
    rnd_cycle(1'b0, 1'b0, 1'b0);
    rnd_cycle(1'b0, 1'b0, 1'b1);
    rnd_cycle(1'b0, 1'b0, 1'b1);

    // Fill to full, then a rejected 9th push that must never appear at the head
    for (int i = 0; i < DEPTH; i++) rnd_cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 2'd3, 3'd4);

    // Full with push and pop together: pop wins, push dropped
    rnd_cycle(1'b0, 1'b1, 1'b1);

    // Drain to 3, then 20 cycles of streaming push+pop through the wrap point
    for (int i = 0; i < 4; i++) rnd_cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) rnd_cycle(1'b0, 1'b1, 1'b1);

    // Grow to 5, then reset mid-transfer with push/pop offered
    for (int i = 0; i < 2; i++) rnd_cycle(1'b0, 1'b1, 1'b0);
    rnd_cycle(1'b1, 1'b1, 1'b1);
    rnd_cycle(1'b0, 1'b0, 1'b0);

    // Saturate drop_cnt with 300 rejected pushes into a full FIFO
    for (int i = 0; i < DEPTH; i++) rnd_cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) rnd_cycle(1'b0, 1'b1, 1'b0);

    // Drain, then pops on an empty FIFO
    for (int i = 0; i < DEPTH + 3; i++) rnd_cycle(1'b0, 1'b0, 1'b1);

    // Almost-full threshold crossing up and down
    for (int i = 0; i < AF_LEVEL; i++) rnd_cycle(1'b0, 1'b1, 1'b0);
    rnd_cycle(1'b0, 1'b0, 1'b0);
    rnd_cycle(1'b0, 1'b0, 1'b1);
    rnd_cycle(1'b0, 1'b0, 1'b0);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++)
      rnd_cycle(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
